alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the 6809/6309 core datapath, the sequential companion of the combinational ALU. It computes unsigned/signed W×W→2W products and 2W÷W quotient/remainder pairs (covering 6809 MUL and 6309 MULD/DIVD/DIVQ at W=8/16) with a start/busy/done handshake and produces 6809-style N/Z/V/C flags plus a divide-by-zero indication. One radix-2 step per clock keeps area small, and the datapath is shared between multiply and divide.

---
 rtl/alu_muldiv.sv | 166 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit: W x W -> 2W products and 2W / W
// quotient/remainder, one step per clock on a datapath shared by both operations.
module alu_muldiv #(
    parameter int W = 16
) (
    input  logic           clk_in,
    input  logic           nrst_in,
    input  logic           start_in,
    input  logic [1:0]     op_in,
    input  logic [2*W-1:0] a_in,
    input  logic [W-1:0]   b_in,
    output logic           busy_out,
    output logic           done_out,
    output logic [W-1:0]   hi_out,
    output logic [W-1:0]   lo_out,
    output logic [3:0]     flags_out,
    output logic           dz_out
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    // IDLE: waiting for start | RUN: W shift steps | FIX: sign fix-up and result write
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    typedef enum logic [1:0] {ET_NONE, ET_DZ, ET_OVF} early_t;

    state_t         state;
    early_t         early;
    logic [1:0]     op;
    logic           neg_q;
    logic           neg_r;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   bm;

    logic           is_div, is_sgn, sa_mul, sa_div, sb;
    logic [W-1:0]   b_mag, a_lo_mag;
    logic [2*W-1:0] a_mag;
    logic           early_dz, early_ovf;
    logic [W:0]     mul_sum, div_diff;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   q_s, r_s;
    logic           sgn_ovf;

    always_comb begin
        is_div    = op_in[1];
        is_sgn    = op_in[0];
        sb        = is_sgn & b_in[W-1];
        sa_mul    = is_sgn & a_in[W-1];
        sa_div    = is_sgn & a_in[2*W-1];
        b_mag     = sb ? -b_in : b_in;
        a_lo_mag  = sa_mul ? -a_in[W-1:0] : a_in[W-1:0];
        a_mag     = sa_div ? -a_in : a_in;
        early_dz  = is_div && (b_in == '0);
        early_ovf = is_div && !early_dz && (a_mag[2*W-1:W] >= b_mag);
    end

    // Partial remainder stays below |b|, so the borrow bit alone decides the quotient bit.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bm} : '0);
        div_diff = acc[2*W-1:W-1] - {1'b0, bm};
        div_ge   = ~div_diff[W];
        div_rem  = div_ge ? div_diff[W-1:0] : acc[2*W-2:W-1];
    end

    always_comb begin
        prod_s  = neg_q ? -acc : acc;
        q_s     = neg_q ? -acc[W-1:0] : acc[W-1:0];
        r_s     = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        sgn_ovf = op[0] && (neg_q ? (acc[W-1:0] > HALF) : acc[W-1]);
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state     <= IDLE;
            early     <= ET_NONE;
            op        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            bm        <= '0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
            flags_out <= '0;
            dz_out    <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op       <= op_in;
                        busy_out <= 1'b1;
                        if (is_div) begin
                            neg_q <= sa_div ^ sb;
                            neg_r <= sa_div;
                            bm    <= b_mag;
                            acc   <= a_mag;
                        end else begin
                            neg_q <= sa_mul ^ sb;
                            neg_r <= 1'b0;
                            bm    <= a_lo_mag;
                            acc   <= {{W{1'b0}}, b_mag};
                        end
                        if (early_dz) begin
                            early <= ET_DZ;
                            acc   <= a_in;
                            cnt   <= '0;
                            state <= FIX;
                        end else if (early_ovf) begin
                            early <= ET_OVF;
                            cnt   <= '0;
                            state <= FIX;
                        end else begin
                            early <= ET_NONE;
                            cnt   <= CW'(W);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op[1])
                        acc <= {div_rem, acc[W-2:0], div_ge};
                    else
                        acc <= {mul_sum, acc[W-1:1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    dz_out   <= (early == ET_DZ);
                    if (early == ET_DZ) begin
                        hi_out    <= acc[W-1:0];
                        lo_out    <= '1;
                        flags_out <= 4'b0010;
                    end else if (early == ET_OVF) begin
                        hi_out    <= '0;
                        lo_out    <= '0;
                        flags_out <= 4'b0010;
                    end else if (!op[1]) begin
                        hi_out    <= prod_s[2*W-1:W];
                        lo_out    <= prod_s[W-1:0];
                        flags_out <= {prod_s[2*W-1], prod_s == '0, 1'b0, prod_s[W-1]};
                    end else if (sgn_ovf) begin
                        hi_out    <= '0;
                        lo_out    <= '0;
                        flags_out <= 4'b0010;
                    end else begin
                        hi_out    <= r_s;
                        lo_out    <= q_s;
                        flags_out <= {q_s[W-1], q_s == '0, 1'b0, q_s[0]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: W=8 and W=16 instances, directed vectors,
// expected results queued at accept and checked by a monitor on done_out.
module tb_alu_muldiv;

    typedef struct {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  flags;
        logic [3:0]  fmask;
        logic        dz;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start8, start16;
    logic [1:0]  op8, op16;
    logic [15:0] a8;
    logic [7:0]  b8;
    logic [31:0] a16;
    logic [15:0] b16;
    logic        busy8, done8, dz8, busy16, done16, dz16;
    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    logic [3:0]  flags8, flags16;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q16[$];

    alu_muldiv #(.W(8)) dut8 (
        .clk_in(clk), .nrst_in(nrst), .start_in(start8), .op_in(op8),
        .a_in(a8), .b_in(b8), .busy_out(busy8), .done_out(done8),
        .hi_out(hi8), .lo_out(lo8), .flags_out(flags8), .dz_out(dz8)
    );

    alu_muldiv #(.W(16)) dut16 (
        .clk_in(clk), .nrst_in(nrst), .start_in(start16), .op_in(op16),
        .a_in(a16), .b_in(b16), .busy_out(busy16), .done_out(done16),
        .hi_out(hi16), .lo_out(lo16), .flags_out(flags16), .dz_out(dz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic check_pop(input bit sel, input logic [31:0] hi, input logic [31:0] lo,
                             input logic [3:0] fl, input logic dz, input logic busy);
        exp_t e;
        if ((sel && q16.size() == 0) || (!sel && q8.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected no completion", sel ? 16 : 8);
            return;
        end
        e = sel ? q16.pop_front() : q8.pop_front();
        chk("hi", e.id, hi, e.hi);
        chk("lo", e.id, lo, e.lo);
        chk("flags", e.id, 32'(fl & e.fmask), 32'(e.flags & e.fmask));
        chk("dz", e.id, 32'(dz), 32'(e.dz));
        chk("busy_at_done", e.id, 32'(busy), 32'd0);
        chk("latency", e.id, 32'(cyc - e.acc_cyc), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (done8)  check_pop(1'b0, 32'(hi8), 32'(lo8), flags8, dz8, busy8);
        if (done16) check_pop(1'b1, 32'(hi16), 32'(lo16), flags16, dz16, busy16);
    end

    // Called between edges; returns just after a falling edge.
    task automatic send(input bit sel, input int id, input logic [1:0] op, input logic [31:0] a,
                        input logic [15:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [3:0] efl, input logic [3:0] efm, input logic edz,
                        input int elat, input int hold);
        exp_t e;
        int   n;
        if (sel) begin op16 = op; a16 = a; b16 = b; start16 = 1'b1; end
        else begin op8 = op; a8 = a[15:0]; b8 = b[7:0]; start8 = 1'b1; end
        n = 0;
        while ((sel ? busy16 : busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout (vec %0d): got busy=1, expected idle", id);
        end
        @(posedge clk);
        #1;
        e.id = id; e.hi = ehi; e.lo = elo; e.flags = efl; e.fmask = efm;
        e.dz = edz; e.lat = elat; e.acc_cyc = cyc;
        if (sel) q16.push_back(e); else q8.push_back(e);
        if (hold > 0) begin
            if (sel) begin op16 = ~op; a16 = ~a; b16 = ~b; end
            else begin op8 = ~op; a8 = ~a[15:0]; b8 = ~b[7:0]; end
            repeat (hold) @(negedge clk);
        end
        if (sel) start16 = 1'b0; else start8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input bit sel, input int id);
        int n = 0;
        while (!(sel ? done16 : done8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout (vec %0d): got done=0, expected a completion", id);
        end
    endtask

    task automatic drain;
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q8.size(), q16.size());
        end
    endtask

    task automatic check_cleared(input int id);
        chk("rst_busy8", id, 32'(busy8), 32'd0);
        chk("rst_done8", id, 32'(done8), 32'd0);
        chk("rst_hi8", id, 32'(hi8), 32'd0);
        chk("rst_lo8", id, 32'(lo8), 32'd0);
        chk("rst_flags8", id, 32'(flags8), 32'd0);
        chk("rst_dz8", id, 32'(dz8), 32'd0);
        chk("rst_busy16", id, 32'(busy16), 32'd0);
        chk("rst_hi16", id, 32'(hi16), 32'd0);
        chk("rst_lo16", id, 32'(lo16), 32'd0);
        chk("rst_flags16", id, 32'(flags16), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check_cleared(0);
        nrst = 1'b1;
        @(negedge clk);

        // W=16: DIVS -7/2 and MULU 0xFFFF*0xFFFF
        send(1, 1, 2'b11, 32'hFFFF_FFF9, 16'h0002, 32'hFFFF, 32'hFFFD, 4'b1001, 4'hF, 1'b0, 17, 0);
        send(1, 2, 2'b00, 32'h0000_FFFF, 16'hFFFF, 32'hFFFE, 32'h0001, 4'b1000, 4'hF, 1'b0, 17, 0);

        // W=8 directed vectors
        send(0, 10, 2'b00, 32'h00FF, 16'h00FF, 32'hFE, 32'h01, 4'b1000, 4'hF, 1'b0, 9, 0);
        send(0, 11, 2'b01, 32'h0080, 16'h0080, 32'h40, 32'h00, 4'b0000, 4'hF, 1'b0, 9, 0);
        send(0, 12, 2'b01, 32'h0007, 16'h00FD, 32'hFF, 32'hEB, 4'b1001, 4'hF, 1'b0, 9, 0);
        send(0, 13, 2'b10, 32'h1234, 16'h0000, 32'h34, 32'hFF, 4'b0010, 4'hF, 1'b1, 1, 0);
        send(0, 14, 2'b10, 32'h1234, 16'h0012, 32'h00, 32'h00, 4'b0010, 4'hF, 1'b0, 1, 0);
        send(0, 15, 2'b11, 32'h0080, 16'h0001, 32'h00, 32'h00, 4'b0010, 4'b0010, 1'b0, 9, 0);
        send(0, 16, 2'b11, 32'hFF80, 16'h0001, 32'h00, 32'h80, 4'b1000, 4'hF, 1'b0, 9, 0);
        send(0, 17, 2'b00, 32'h0000, 16'h0055, 32'h00, 32'h00, 4'b0100, 4'hF, 1'b0, 9, 0);

        // start held high (inputs scrambled) through the busy period
        send(0, 18, 2'b00, 32'h0012, 16'h0034, 32'h03, 32'hA8, 4'b0001, 4'hF, 1'b0, 9, 8);

        // back-to-back: next start issued during the done cycle
        wait_done(0, 18);
        send(0, 19, 2'b10, 32'h1234, 16'h0056, 32'h10, 32'h36, 4'b0000, 4'hF, 1'b0, 9, 0);
        wait_done(0, 19);
        send(0, 20, 2'b11, 32'h0064, 16'h00F9, 32'h02, 32'hF2, 4'b1000, 4'hF, 1'b0, 9, 0);
        drain();

        // reset in the middle of RUN: outputs clear, no completion follows
        send(0, 21, 2'b00, 32'h00FF, 16'h00FF, 32'hFE, 32'h01, 4'b1000, 4'hF, 1'b0, 9, 0);
        repeat (3) @(negedge clk);
        #2 nrst = 1'b0;
        #1 check_cleared(21);
        q8.delete();
        #1 nrst = 1'b1;
        repeat (12) @(negedge clk);
        send(0, 22, 2'b01, 32'h0007, 16'h00FD, 32'hFF, 32'hEB, 4'b1001, 4'hF, 1'b0, 9, 0);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
